// File: rtl/mult8x8_pkg.sv
// Shared types and constants for the quadrant-sequenced 8x8 multiplier.
package mult8x8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam logic [1:0] Q_LL = 2'd0;
  localparam logic [1:0] Q_LH = 2'd1;
  localparam logic [1:0] Q_HL = 2'd2;
  localparam logic [1:0] Q_HH = 2'd3;

  localparam logic [3:0] Q_SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  // Returns {found, index} of the lowest enabled quadrant at or above 'from'.
  function automatic logic [2:0] first_enabled(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!res[2] && (i >= 32'(from)) && mask[i]) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mul4x4_cell.sv
// Exact combinational 4x4 multiplier cell; approximate cells may share this port list.
module mul4x4_cell (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0, a} * {4'b0, b};

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequencing controller: one 4x4 cell time-shared over four quadrants,
// combined by ADD or OR under a snapshotted mode/quadrant-mask configuration.
module mult8x8_seq_ctrl #(
  parameter logic       MODE_RST  = 1'b0,
  parameter logic [3:0] QMASK_RST = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_mode,
  input  logic [3:0]  cfg_qmask,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy
);
  import mult8x8_pkg::*;

  state_e      state_q, state_d;
  logic [1:0]  qidx_q, qidx_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        mode_q, mode_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] acc_q, acc_d, r_q, r_d;
  logic        cfg_mode_q;
  logic [3:0]  cfg_mask_q;

  logic [3:0]  cell_a, cell_b;
  logic [7:0]  pp;
  logic [15:0] pp_sh, combined;
  logic [2:0]  first_q, next_q;

  assign cell_a = (qidx_q == Q_HL || qidx_q == Q_HH) ? a_q[7:4] : a_q[3:0];
  assign cell_b = (qidx_q == Q_LH || qidx_q == Q_HH) ? b_q[7:4] : b_q[3:0];

  mul4x4_cell u_cell (
    .a (cell_a),
    .b (cell_b),
    .p (pp)
  );

  assign pp_sh    = {8'b0, pp} << Q_SHIFT[qidx_q];
  assign combined = (mode_q == MODE_OR) ? (acc_q | pp_sh) : (acc_q + pp_sh);
  assign first_q  = first_enabled(cfg_mask_q, 3'd0);
  assign next_q   = first_enabled(mask_q, {1'b0, qidx_q} + 3'd1);

  always_comb begin
    state_d = state_q;
    qidx_d  = qidx_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d    = A;
          b_d    = B;
          mode_d = cfg_mode_q;
          mask_d = cfg_mask_q;
          acc_d  = '0;
          if (first_q[2]) begin
            state_d = CALC;
            qidx_d  = first_q[1:0];
          end else begin
            state_d = DONE;
            r_d     = '0;
          end
        end
      end
      CALC: begin
        acc_d = combined;
        if (next_q[2]) begin
          qidx_d = next_q[1:0];
        end else begin
          state_d = DONE;
          r_d     = combined;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      qidx_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_RST;
      mask_q  <= QMASK_RST;
      acc_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      qidx_q  <= qidx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
    end
  end

  // Snapshot above reads the pre-write value when cfg_we and accept coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mode_q <= MODE_RST;
      cfg_mask_q <= QMASK_RST;
    end else if (cfg_we) begin
      cfg_mode_q <= cfg_mode;
      cfg_mask_q <= cfg_qmask;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign R         = r_q;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Directed, table-driven bench for mult8x8_seq_ctrl plus hand-written corner sequences.
module tb_mult8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [3:0]  cfg_qmask = 4'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  A = 8'h0;
  logic [7:0]  B = 8'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] R;
  logic        busy;

  int total = 0;
  int bad = 0;

  mult8x8_seq_ctrl #(.MODE_RST(1'b0), .QMASK_RST(4'b1111)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_mode  (cfg_mode),
    .cfg_qmask (cfg_qmask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  mask;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] r;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic write_cfg(input logic mode, input logic [3:0] mask);
    cfg_we = 1'b1; cfg_mode = mode; cfg_qmask = mask;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Accept happens on the next edge (cycle 0); lat counts cycles until out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output logic [15:0] r,
                        output bit rdy_low);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_low = 1'b1;
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_low = 1'b0;
    r = R;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] r;
    bit rl;

    vecs[0] = '{1'b1, 4'b1111, 8'h35, 8'h27, 5, 16'h07F3};
    vecs[1] = '{1'b0, 4'b1111, 8'h35, 8'h27, 5, 16'h0813};
    vecs[2] = '{1'b0, 4'b1110, 8'hFF, 8'hFF, 4, 16'hFD20};
    vecs[3] = '{1'b0, 4'b0000, 8'h12, 8'h34, 1, 16'h0000};
    vecs[4] = '{1'b0, 4'b0001, 8'hFF, 8'hFF, 2, 16'h00E1};
    vecs[5] = '{1'b1, 4'b1001, 8'hFF, 8'hFF, 3, 16'hE1E1};
    vecs[6] = '{1'b0, 4'b0110, 8'h35, 8'h27, 3, 16'h01F0};
    vecs[7] = '{1'b0, 4'b1111, 8'h00, 8'hFF, 5, 16'h0000};
    vecs[8] = '{1'b0, 4'b1111, 8'h10, 8'h10, 5, 16'h0100};
    vecs[9] = '{1'b1, 4'b0000, 8'hFF, 8'hFF, 1, 16'h0000};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_R", 32'(R), 32'd0);

    // Default configuration after reset
    run_op(8'hFF, 8'hFF, lat, r, rl);
    check("dflt_lat", 32'(lat), 32'd5);
    check("dflt_R", 32'(r), 32'hFE01);
    check("dflt_in_ready_low", 32'(rl), 32'd1);
    release_result();

    for (int i = 0; i < 10; i++) begin
      write_cfg(vecs[i].mode, vecs[i].mask);
      run_op(vecs[i].a, vecs[i].b, lat, r, rl);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_R", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_in_ready_low", i), 32'(rl), 32'd1);
      release_result();
    end

    // Back-pressure in DONE, then one IDLE cycle before the next accept
    write_cfg(1'b0, 4'b1111);
    run_op(8'h35, 8'h27, lat, r, rl);
    check("bp_R", 32'(r), 32'h0813);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_R%0d", i), 32'(R), 32'h0813);
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    release_result();
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    run_op(8'h10, 8'h10, lat, r, rl);
    check("bp_next_lat", 32'(lat), 32'd5);
    check("bp_next_R", 32'(r), 32'h0100);
    release_result();

    // Config write coinciding with accept: op uses old mode, next op uses new
    write_cfg(1'b0, 4'b1111);
    cfg_we = 1'b1; cfg_mode = 1'b1; cfg_qmask = 4'b1111;
    A = 8'h35; B = 8'h27; in_valid = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("coin_lat", 32'(lat), 32'd5);
    check("coin_R", 32'(R), 32'h0813);
    release_result();
    run_op(8'h35, 8'h27, lat, r, rl);
    check("coin_next_R", 32'(r), 32'h07F3);
    release_result();

    // Asynchronous reset in the middle of CALC restores reset config
    write_cfg(1'b1, 4'b0011);
    A = 8'hFF; B = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_R", 32'(R), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'hFF, 8'hFF, lat, r, rl);
    check("post_rst_lat", 32'(lat), 32'd5);
    check("post_rst_R", 32'(r), 32'hFE01);
    release_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
